pong_score_keeper: RTL and testbench
====================================

# pong_score_keeper

Score-keeping stage for Pong, directly upstream of the eight-digit seven-segment display driver. It counts point events from the ball/collision logic, decides when a game is won, tracks games won per player and packs everything into the 32-bit, eight-hex-digit word the display driver consumes. All counts are held in BCD so the display shows decimal.

## Interface
- `WIN_SCORE`, default 11: points needed to win a game. Binary value, legal range 1–99.
- `clk` input 1: system clock. All state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `point_l` input 1: left player scored. Synchronous level; only the rising edge counts.
- `point_r` input 1: right player scored. Synchronous level; only the rising edge counts.
- `new_game` input 1: start a new game. Synchronous level; only the rising edge counts.
- `disp_word` output 32: packed digits for the display driver.
  - [31:24]: left score, BCD.
  - [23:16]: left games won, BCD.
  - [15:8]: right games won, BCD.
  - [7:0]: right score, BCD.
- `game_over` output 1: high while in state OVER.
- `winner` output 1: winner of the last completed game (0 = left, 1 = right). Held until the next game ends or `rst`.

## Operation
- **Edge detection**
  - A registered copy of each input is kept. Event = input high AND previous sample low.
  - A held-high input counts exactly once.
- **State PLAY**
  - A `point_l` event alone adds 1 to the left score. A `point_r` event alone adds 1 to the right score.
  - BCD increment: the ones digit wraps 9→0 and carries into the tens digit.
  - Scores saturate at 99.
  - Win check uses the post-increment value.
  - When a game is won: the winner's games-won count increments (BCD, saturating at 99), `winner` is loaded, and the FSM goes to OVER. All of this happens on the same edge as the winning point.
- **State OVER**
  - Point events are ignored.
  - Scores stay frozen on the display.
- **`new_game` event, either state**
  - Clears both scores to 00 and goes to PLAY.
  - Games-won counts and `winner` are kept.
  - If issued in PLAY, it aborts the game with no credit.
- **Simultaneous events**
  - `point_l` and `point_r` in the same cycle: both are dropped and nothing changes.
  - `new_game` together with any point event: `new_game` wins and the point is dropped.
- **Reset values**
  - All scores and games-won counts are 0 and the FSM is in PLAY.
  - `disp_word` = 32'h0000_0000, `game_over` = 0, `winner` = 0.
  - Edge-detect registers reset to 0, so an input already high when `rst` is released counts as an event on the first clock.
- **Reset mid-game** clears everything immediately and asynchronously. There is no partial update.

## Timing
- All outputs are registered.
- An event sampled at edge k (input high at k, low at k−1) is reflected in `disp_word`, `game_over` and `winner` immediately after edge k. The update takes one edge; there is no extra pipeline stage.
- Back-to-back events need the input to go low for at least one cycle between them. Maximum rate is one point every 2 cycles per input.
- `disp_word` is stable between events. The display driver may sample it asynchronously to its own scan.

## Configuration
- `WIN_BY_TWO_EN`
  - **Defined:** a game is won only when the scorer has at least `WIN_SCORE` points AND leads by at least 2. If the scorer reaches 99 with a lead under 2, that scorer wins immediately.
  - **Undefined:** the first player to reach `WIN_SCORE` wins, regardless of margin.

## Test plan
- **Reset and first points:** apply `rst`, then three separate `point_l` pulses → `disp_word` = 32'h0300_0000, `game_over` = 0.
- **BCD carry:** with `WIN_SCORE` = 15, give 10 `point_r` pulses → `disp_word[7:0]` = 8'h10. Holding `point_r` high for 5 cycles adds only 1 → 8'h11.
- **Game win:** `WIN_SCORE` = 11, left reaches 11 with right at 4 → after that edge `disp_word` = 32'h1101_0004, `game_over` = 1, `winner` = 0. A further `point_r` leaves it unchanged. `new_game` → 32'h0001_0000, `game_over` = 0.
- **Simultaneous events:**
  - `point_l` and `point_r` in the same cycle → no change.
  - `new_game` together with `point_l` → scores 00, no increment.
- **`WIN_BY_TWO_EN` defined:** scores 11–10 → no win. Right scores to 11–11, then 11–12, then 11–13 → `game_over` = 1, `winner` = 1, `disp_word` = 32'h1100_0113.
- **Asynchronous reset mid-game:** assert `rst` between clock edges at 07–05 → outputs go to 0 before the next edge.

Source files
------------

// File: rtl/pong_score_keeper.sv
// Pong score keeper: BCD points, games won and win detection packed for the 8-digit display.
// Optional WIN_BY_TWO_EN: a game also needs a 2-point lead (reaching 99 wins outright).
module pong_score_keeper #(
  parameter int WIN_SCORE = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        point_l,
  input  logic        point_r,
  input  logic        new_game,
  output logic [31:0] disp_word,
  output logic        game_over,
  output logic        winner
);

  typedef enum logic {PLAY, OVER} state_t;

  localparam logic [6:0] WIN7 = 7'(WIN_SCORE);

  state_t     state_q, state_d;
  logic       pl_q, pr_q, pn_q;
  logic [7:0] sl_q, sl_d, sr_q, sr_d;
  logic [7:0] gl_q, gl_d, gr_q, gr_d;
  logic       win_q, win_d;

  logic       ev_l, ev_r, ev_n;
  logic       add_l, add_r;
  logic       win_l, win_r;
  logic [7:0] inc_l, inc_r;
  logic [6:0] bin_il, bin_ir;

  // BCD +1, saturating at 99
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_bin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  assign ev_l = point_l & ~pl_q;
  assign ev_r = point_r & ~pr_q;
  assign ev_n = new_game & ~pn_q;

  assign add_l = (state_q == PLAY) & ~ev_n & ev_l & ~ev_r;
  assign add_r = (state_q == PLAY) & ~ev_n & ev_r & ~ev_l;

  assign inc_l  = bcd_inc(sl_q);
  assign inc_r  = bcd_inc(sr_q);
  assign bin_il = bcd_bin(inc_l);
  assign bin_ir = bcd_bin(inc_r);

`ifdef WIN_BY_TWO_EN
  logic [6:0] bin_l, bin_r;
  assign bin_l = bcd_bin(sl_q);
  assign bin_r = bcd_bin(sr_q);
  assign win_l = (bin_il >= WIN7 && bin_il >= bin_r + 7'd2)
               || inc_l == 8'h99;
  assign win_r = (bin_ir >= WIN7 && bin_ir >= bin_l + 7'd2)
               || inc_r == 8'h99;
`else
  assign win_l = bin_il >= WIN7;
  assign win_r = bin_ir >= WIN7;
`endif

  always_comb begin
    state_d = state_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    gl_d    = gl_q;
    gr_d    = gr_q;
    win_d   = win_q;
    unique case (1'b1)
      ev_n: begin
        sl_d    = 8'h00;
        sr_d    = 8'h00;
        state_d = PLAY;
      end
      add_l: begin
        sl_d = inc_l;
        if (win_l) begin
          gl_d    = bcd_inc(gl_q);
          win_d   = 1'b0;
          state_d = OVER;
        end
      end
      add_r: begin
        sr_d = inc_r;
        if (win_r) begin
          gr_d    = bcd_inc(gr_q);
          win_d   = 1'b1;
          state_d = OVER;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PLAY;
      pl_q    <= 1'b0;
      pr_q    <= 1'b0;
      pn_q    <= 1'b0;
      sl_q    <= 8'h00;
      sr_q    <= 8'h00;
      gl_q    <= 8'h00;
      gr_q    <= 8'h00;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pl_q    <= point_l;
      pr_q    <= point_r;
      pn_q    <= new_game;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      gl_q    <= gl_d;
      gr_q    <= gr_d;
      win_q   <= win_d;
    end
  end

  assign disp_word = {sl_q, gl_q, gr_q, sr_q};
  assign game_over = (state_q == OVER);
  assign winner    = win_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper: directed steps plus random play against an integer model.
module tb_pong_score_keeper;

  localparam int W = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        point_l = 1'b0;
  logic        point_r = 1'b0;
  logic        new_game = 1'b0;
  logic [31:0] disp_word;
  logic        game_over;
  logic        winner;

  int tests = 0;
  int fails = 0;

  int sl, sr, gl, gr;
  bit over, win;
  bit pl, pr, pn;

  pong_score_keeper #(.WIN_SCORE(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .point_l  (point_l),
    .point_r  (point_r),
    .new_game (new_game),
    .disp_word(disp_word),
    .game_over(game_over),
    .winner   (winner)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic bit won(input int a, input int b);
`ifdef WIN_BY_TWO_EN
    return (a >= W && a - b >= 2) || a == 99;
`else
    return (a >= W) || (b < 0);
`endif
  endfunction

  function automatic int sat(input int v);
    return (v >= 99) ? 99 : v + 1;
  endfunction

  task automatic model_clear();
    sl = 0; sr = 0; gl = 0; gr = 0;
    over = 0; win = 0;
    pl = 0; pr = 0; pn = 0;
  endtask

  task automatic model_clk(input bit l, input bit r, input bit n);
    bit el, er, en;
    el = l && !pl;
    er = r && !pr;
    en = n && !pn;
    pl = l; pr = r; pn = n;
    if (en) begin
      sl = 0; sr = 0; over = 0;
    end else if (!over && el != er) begin
      if (el) begin
        sl = sat(sl);
        if (won(sl, sr)) begin
          gl = sat(gl); win = 0; over = 1;
        end
      end else begin
        sr = sat(sr);
        if (won(sr, sl)) begin
          gr = sat(gr); win = 1; over = 1;
        end
      end
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk32({tag, "_word"}, disp_word, {bcd(sl), bcd(gl), bcd(gr), bcd(sr)});
    chk1({tag, "_over"}, game_over, over);
    chk1({tag, "_winner"}, winner, win);
  endtask

  task automatic step(input bit l, input bit r, input bit n,
                      input string tag);
    @(negedge clk);
    point_l = l; point_r = r; new_game = n;
    @(posedge clk);
    model_clk(l, r, n);
    #1;
    check_model(tag);
  endtask

  task automatic pulse(input bit l, input bit r, input string tag);
    step(l, r, 1'b0, tag);
    step(1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    point_l = 0; point_r = 0; new_game = 0;
    rst = 1;
    model_clear();
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    model_clear();
    do_reset();
    chk32("reset_const", disp_word, 32'h0000_0000);

    for (int i = 0; i < 3; i++) pulse(1, 0, "first_pts");
    chk32("first_pts_const", disp_word, 32'h0300_0000);
    chk1("first_pts_over", game_over, 1'b0);

    for (int i = 0; i < 4; i++) pulse(0, 1, "win_r4");
    for (int i = 0; i < 8; i++) pulse(1, 0, "win_l");
    chk32("win_const", disp_word, 32'h1101_0004);
    chk1("win_over", game_over, 1'b1);
    chk1("win_winner", winner, 1'b0);
    pulse(0, 1, "over_ignore");
    chk32("over_ignore_const", disp_word, 32'h1101_0004);
    pulse(0, 0, "idle");
    step(0, 0, 1, "new_game");
    chk32("new_game_const", disp_word, 32'h0001_0000);
    chk1("new_game_over", game_over, 1'b0);
    step(0, 0, 0, "new_game_low");

    for (int i = 0; i < 10; i++) pulse(0, 1, "carry");
    chk32("carry_const", {24'h0, disp_word[7:0]}, 32'h10);
    for (int i = 0; i < 5; i++) step(0, 1, 0, "hold");
    chk32("hold_const", {24'h0, disp_word[7:0]}, 32'h11);
    step(0, 0, 0, "hold_low");

    step(0, 0, 1, "ng2");
    step(0, 0, 0, "ng2_low");
    pulse(1, 0, "pre_sim");
    step(1, 1, 0, "sim_lr");
    chk32("sim_lr_const", disp_word, 32'h0101_0100);
    step(0, 0, 0, "sim_low");
    step(1, 0, 1, "sim_ng");
    chk32("sim_ng_const", disp_word, 32'h0001_0100);
    step(0, 0, 0, "sim_ng_low");

    do_reset();
    for (int i = 0; i < 7; i++) pulse(1, 0, "mid_l");
    for (int i = 0; i < 5; i++) pulse(0, 1, "mid_r");
    chk32("mid_const", disp_word, 32'h0700_0005);
    @(negedge clk);
    #1;
    rst = 1;
    model_clear();
    #1;
    chk32("async_rst_word", disp_word, 32'h0000_0000);
    chk1("async_rst_over", game_over, 1'b0);
    check_model("async_rst");
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 29) == 0), "rand");
    end
    step(0, 0, 0, "rand_end");

`ifdef WIN_BY_TWO_EN
    do_reset();
    for (int i = 0; i < 10; i++) pulse(1, 0, "w2_l");
    for (int i = 0; i < 10; i++) pulse(0, 1, "w2_r");
    pulse(1, 0, "w2_11_10");
    chk1("w2_no_win", game_over, 1'b0);
    for (int i = 0; i < 3; i++) pulse(0, 1, "w2_r_run");
    chk32("w2_const", disp_word, 32'h1100_0113);
    chk1("w2_over", game_over, 1'b1);
    chk1("w2_winner", winner, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
